// File: rtl/ysyx_22050019_idu_stage.sv
// Decode stage between IFU and EXU: registers the decoded instruction and stalls on RAW hazards via a per-register scoreboard.
// Latency: one cycle from input acceptance to out_valid.
// Backpressure: in_ready drops while the output register is held, on a RAW or scoreboard-saturation hazard, or during flush.
module ysyx_22050019_idu_stage #(
  parameter int XLEN   = 64,
  parameter int NR_REG = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      raddr1,
  output logic [4:0]      raddr2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_reg_we,
  output logic [9:0]      out_class,
  output logic            out_word,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  // Bit positions inside out_class
  localparam int C_OP     = 0;
  localparam int C_OP_IMM = 1;
  localparam int C_LOAD   = 2;
  localparam int C_STORE  = 3;
  localparam int C_BRANCH = 4;
  localparam int C_JAL    = 5;
  localparam int C_JALR   = 6;
  localparam int C_LUI    = 7;
  localparam int C_AUIPC  = 8;
  localparam int C_CSR    = 9;

  localparam logic [5:0]        NR_LIM   = 6'(NR_REG);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic              RV32     = (XLEN == 32);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            reg_we;
    logic [9:0]      cls;
    logic            word;
    logic            illegal;
  } dec_t;

  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [4:0]         rs1, rs2, rd;
  logic               use1, use2, has_rd, bad_opc, word, range_bad, illegal, reg_we;
  logic [9:0]         cls;
  logic signed [31:0] imm32;
  dec_t               cand;

  logic               valid_q, valid_d;
  dec_t               out_q, out_d;
  logic [PEND_W-1:0]  pend_q [32];
  logic [PEND_W-1:0]  pend_d [32];

  logic               hit1, hit2, hit_rd, raw, sat, hazard, accept, xfer;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];
  assign rd  = in_inst[11:7];

  // Classify the opcode, pick the immediate format and which register fields are live
  always_comb begin
    use1    = 1'b0;
    use2    = 1'b0;
    has_rd  = 1'b0;
    bad_opc = 1'b0;
    word    = 1'b0;
    cls     = '0;
    imm32   = '0;
    case (opc)
      OPC_OP: begin
        cls[C_OP] = 1'b1; use1 = 1'b1; use2 = 1'b1; has_rd = 1'b1;
      end
      OPC_OP_IMM: begin
        cls[C_OP_IMM] = 1'b1; use1 = 1'b1; has_rd = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_LOAD: begin
        cls[C_LOAD] = 1'b1; use1 = 1'b1; has_rd = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_STORE: begin
        cls[C_STORE] = 1'b1; use1 = 1'b1; use2 = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OPC_BRANCH: begin
        cls[C_BRANCH] = 1'b1; use1 = 1'b1; use2 = 1'b1;
        imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        cls[C_JAL] = 1'b1; has_rd = 1'b1;
        imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        cls[C_JALR] = 1'b1; use1 = 1'b1; has_rd = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_LUI: begin
        cls[C_LUI] = 1'b1; has_rd = 1'b1;
        imm32 = {in_inst[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        cls[C_AUIPC] = 1'b1; has_rd = 1'b1;
        imm32 = {in_inst[31:12], 12'b0};
      end
      OPC_SYSTEM: begin
        // funct3[2] selects the immediate (zimm) CSR forms; funct3==0 is ecall/ebreak
        cls[C_CSR] = 1'b1; use1 = ~f3[2]; has_rd = (f3 != 3'b000);
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_IMM32: begin
        cls[C_OP_IMM] = 1'b1; word = 1'b1; use1 = 1'b1; has_rd = 1'b1; bad_opc = RV32;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_OP32: begin
        cls[C_OP] = 1'b1; word = 1'b1; use1 = 1'b1; use2 = 1'b1; has_rd = 1'b1; bad_opc = RV32;
      end
      default: bad_opc = 1'b1;
    endcase
  end

  assign range_bad = (use1 && ({1'b0, rs1} >= NR_LIM)) ||
                     (use2 && ({1'b0, rs2} >= NR_LIM)) ||
                     (has_rd && ({1'b0, rd} >= NR_LIM));
  assign illegal   = bad_opc || range_bad;
  assign reg_we    = has_rd && (rd != 5'd0) && !illegal;

  assign raddr1 = use1 ? rs1 : 5'd0;
  assign raddr2 = use2 ? rs2 : 5'd0;

  // Assemble the candidate output record; illegal instructions carry no class, immediate or write
  always_comb begin
    cand          = '0;
    cand.pc       = in_pc;
    cand.inst     = in_inst;
    cand.rs1_data = rdata1;
    cand.rs2_data = rdata2;
    cand.rd       = rd;
    cand.illegal  = illegal;
    cand.reg_we   = reg_we;
    if (!illegal) begin
      cand.imm  = XLEN'(imm32);
      cand.cls  = cls;
      cand.word = word;
    end
  end

  // A writer sitting in the output register is not yet counted, so it is checked separately
  assign hit1   = valid_q && out_q.reg_we && (out_q.rd == rs1);
  assign hit2   = valid_q && out_q.reg_we && (out_q.rd == rs2);
  assign hit_rd = valid_q && out_q.reg_we && (out_q.rd == rd);
  assign raw    = (use1 && (rs1 != 5'd0) && ((pend_q[rs1] != '0) || hit1)) ||
                  (use2 && (rs2 != 5'd0) && ((pend_q[rs2] != '0) || hit2));
  assign sat    = reg_we && (({1'b0, pend_q[rd]} + {{PEND_W{1'b0}}, hit_rd}) >= {1'b0, PEND_MAX});
  assign hazard = !illegal && (raw || sat);

  assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign xfer     = valid_q && out_ready && !flush;

  // Output register: flush squashes, acceptance loads, a bare transfer empties
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      out_d   = cand;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // Scoreboard: count issued writers, retire on writeback, ignore x0 and empty counters
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      pend_d[i] = pend_q[i];
      if (i != 0 && i < NR_REG) begin
        pend_d[i] = pend_q[i]
                  + PEND_W'(xfer && out_q.reg_we && (out_q.rd == 5'(i)))
                  - PEND_W'(wb_valid && (wb_rd == 5'(i)) && (pend_q[i] != '0));
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      for (int i = 0; i < 32; i++) pend_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      pend_q  <= pend_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = out_q.pc;
  assign out_inst     = out_q.inst;
  assign out_rs1_data = out_q.rs1_data;
  assign out_rs2_data = out_q.rs2_data;
  assign out_imm      = out_q.imm;
  assign out_rd       = out_q.rd;
  assign out_reg_we   = out_q.reg_we;
  assign out_class    = out_q.cls;
  assign out_word     = out_q.word;
  assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_ysyx_22050019_idu_stage.sv
// Bench for the decode stage: RV64/32-register instance checked every cycle against a model,
// plus an RV32/RV-E instance checked with literal expectations.
module tb_ysyx_22050019_idu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, flush, wb_valid;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic [4:0]  wb_rd;
  logic        in_ready, out_valid, out_reg_we, out_word, out_illegal;
  logic [4:0]  raddr1, raddr2, out_rd;
  logic [63:0] rdata1, rdata2, out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [31:0] out_inst;
  logic [9:0]  out_class;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_reg_we, s_out_word, s_out_illegal;
  logic [31:0] s_in_pc, s_in_inst, s_out_pc, s_out_inst, s_out_rs1_data, s_out_rs2_data, s_out_imm;
  logic [4:0]  s_raddr1, s_raddr2, s_out_rd;
  logic [9:0]  s_out_class;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] rf(input logic [4:0] a);
    return 64'hA5A5_0000_0000_0000 | {59'd0, a};
  endfunction

  assign rdata1 = rf(raddr1);
  assign rdata2 = rf(raddr2);

  ysyx_22050019_idu_stage #(.XLEN(64), .NR_REG(32), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd(out_rd), .out_reg_we(out_reg_we), .out_class(out_class), .out_word(out_word),
    .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  ysyx_22050019_idu_stage #(.XLEN(32), .NR_REG(16), .PEND_W(2)) dut_rv32e (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pc(s_in_pc),
    .in_inst(s_in_inst), .raddr1(s_raddr1), .raddr2(s_raddr2), .rdata1(32'd0), .rdata2(32'd0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_pc(s_out_pc), .out_inst(s_out_inst),
    .out_rs1_data(s_out_rs1_data), .out_rs2_data(s_out_rs2_data), .out_imm(s_out_imm),
    .out_rd(s_out_rd), .out_reg_we(s_out_reg_we), .out_class(s_out_class), .out_word(s_out_word),
    .out_illegal(s_out_illegal), .wb_valid(1'b0), .wb_rd(5'd0), .flush(1'b0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the RV64 instance ----------------
  typedef struct {
    logic [9:0]  cls;
    logic [63:0] imm;
    logic        we, word, ill, u1, u2;
    logic [4:0]  rs1, rs2, rd;
  } mdec_t;

  function automatic mdec_t mdec(input logic [31:0] w);
    mdec_t  d;
    longint sw, i_imm, s_imm, b_imm, u_imm, j_imm;
    logic   wr;
    sw    = longint'(int'(w));
    i_imm = sw >>> 20;
    s_imm = ((sw >>> 25) <<< 5) | longint'(w[11:7]);
    b_imm = ((sw >>> 31) <<< 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
    u_imm = longint'(int'({w[31:12], 12'd0}));
    j_imm = ((sw >>> 31) <<< 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
    d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
    d.cls = '0; d.imm = '0; d.word = 0; d.ill = 0; d.u1 = 0; d.u2 = 0; wr = 0;
    case (w[6:0])
      7'h33: begin d.cls = 10'd1 << 0; d.u1 = 1; d.u2 = 1; wr = 1; end
      7'h13: begin d.cls = 10'd1 << 1; d.u1 = 1; wr = 1; d.imm = i_imm; end
      7'h03: begin d.cls = 10'd1 << 2; d.u1 = 1; wr = 1; d.imm = i_imm; end
      7'h23: begin d.cls = 10'd1 << 3; d.u1 = 1; d.u2 = 1; d.imm = s_imm; end
      7'h63: begin d.cls = 10'd1 << 4; d.u1 = 1; d.u2 = 1; d.imm = b_imm; end
      7'h6F: begin d.cls = 10'd1 << 5; wr = 1; d.imm = j_imm; end
      7'h67: begin d.cls = 10'd1 << 6; d.u1 = 1; wr = 1; d.imm = i_imm; end
      7'h37: begin d.cls = 10'd1 << 7; wr = 1; d.imm = u_imm; end
      7'h17: begin d.cls = 10'd1 << 8; wr = 1; d.imm = u_imm; end
      7'h73: begin d.cls = 10'd1 << 9; d.u1 = !w[14]; wr = (w[14:12] != 0); d.imm = i_imm; end
      7'h1B: begin d.cls = 10'd1 << 1; d.word = 1; d.u1 = 1; wr = 1; d.imm = i_imm; end
      7'h3B: begin d.cls = 10'd1 << 0; d.word = 1; d.u1 = 1; d.u2 = 1; wr = 1; end
      default: d.ill = 1;
    endcase
    d.we = wr && (d.rd != 0) && !d.ill;
    return d;
  endfunction

  logic        m_valid, m_we, m_word, m_ill;
  logic [63:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [31:0] m_inst;
  logic [4:0]  m_rd;
  logic [9:0]  m_cls;
  int          pend [32];
  mdec_t       cd;
  logic [4:0]  c_ra1, c_ra2;
  logic        c_haz, c_rdy, c_xfer, c_dec;

  function automatic int in_flight(input logic [4:0] r);
    return (m_valid && m_we && m_rd == r) ? 1 : 0;
  endfunction

  function automatic logic busy(input logic u, input logic [4:0] r);
    return u && (r != 0) && (pend[r] != 0 || in_flight(r) != 0);
  endfunction

  // Compare every cycle on the falling edge, then advance the model to the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      m_valid = 0; m_we = 0; m_word = 0; m_ill = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0;
      m_imm = 0; m_inst = 0; m_rd = 0; m_cls = 0;
      for (int i = 0; i < 32; i++) pend[i] = 0;
    end
    cd    = mdec(in_inst);
    c_ra1 = cd.u1 ? cd.rs1 : 5'd0;
    c_ra2 = cd.u2 ? cd.rs2 : 5'd0;
    c_haz = !cd.ill && (busy(cd.u1, cd.rs1) || busy(cd.u2, cd.rs2) ||
                        (cd.we && (pend[cd.rd] + in_flight(cd.rd) >= 3)));
    c_rdy = (!m_valid || out_ready) && !c_haz && !flush;
    chk("in_ready", in_ready, c_rdy);
    chk("raddr1", raddr1, c_ra1);
    chk("raddr2", raddr2, c_ra2);
    chk("out_valid", out_valid, m_valid);
    chk("out_pc", out_pc, m_pc);
    chk("out_inst", out_inst, m_inst);
    chk("out_rs1_data", out_rs1_data, m_rs1d);
    chk("out_rs2_data", out_rs2_data, m_rs2d);
    chk("out_imm", out_imm, m_imm);
    chk("out_rd", out_rd, m_rd);
    chk("out_reg_we", out_reg_we, m_we);
    chk("out_class", out_class, m_cls);
    chk("out_word", out_word, m_word);
    chk("out_illegal", out_illegal, m_ill);
    if (!rst) begin
      c_xfer = m_valid && out_ready && !flush;
      c_dec  = wb_valid && (wb_rd != 0) && (pend[wb_rd] > 0);
      if (c_xfer && m_we) pend[m_rd]++;
      if (c_dec) pend[wb_rd]--;
      if (flush) begin
        m_valid = 0;
      end else if (in_valid && c_rdy) begin
        m_valid = 1; m_pc = in_pc; m_inst = in_inst; m_rs1d = rf(c_ra1); m_rs2d = rf(c_ra2);
        m_imm = cd.imm; m_rd = cd.rd; m_we = cd.we; m_cls = cd.cls; m_word = cd.word; m_ill = cd.ill;
      end else if (c_xfer) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0; flush = 0; wb_valid = 0; wb_rd = 0;
    in_pc = 0; in_inst = 0; s_in_valid = 0; s_in_pc = 0; s_in_inst = 0;
    cyc(); cyc();
    neg();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_imm", out_imm, 0);
    chk("reset_out_class", out_class, 0);
    cyc();
    rst = 0;

    // addi x1,x0,5 then dependent add x2,x1,x1
    in_pc = 64'h1000; in_inst = 32'h0050_0093; in_valid = 1; out_ready = 1;
    neg(); chk("addi_in_ready", in_ready, 1);
    cyc();
    in_pc = 64'h1004; in_inst = 32'h0010_8133;
    neg();
    chk("addi_out_valid", out_valid, 1);
    chk("addi_imm", out_imm, 64'd5);
    chk("addi_rd", out_rd, 1);
    chk("addi_we", out_reg_we, 1);
    chk("addi_class", out_class, 10'h002);
    chk("raw_stall_inflight", in_ready, 0);
    chk("add_raddr1", raddr1, 1);
    chk("add_raddr2", raddr2, 1);
    cyc();
    neg(); chk("raw_stall_pending", in_ready, 0);
    cyc(); wb_valid = 1; wb_rd = 1;
    neg(); chk("raw_no_bypass", in_ready, 0);
    cyc(); wb_valid = 0;
    neg(); chk("raw_released", in_ready, 1);
    cyc(); in_valid = 0;
    neg();
    chk("add_inst", out_inst, 32'h0010_8133);
    chk("add_class", out_class, 10'h001);
    cyc(); wb_valid = 1; wb_rd = 2;
    cyc(); wb_valid = 0;

    // lui x5,0x80000 sign extension
    in_pc = 64'h1008; in_inst = 32'h8000_02B7; in_valid = 1;
    cyc(); in_valid = 0;
    neg();
    chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_class", out_class, 10'h080);
    cyc(); wb_valid = 1; wb_rd = 5;
    cyc(); wb_valid = 0;

    // unknown opcode passes through as illegal
    in_inst = 32'hFFFF_FFFF; in_valid = 1;
    cyc(); in_valid = 0;
    neg();
    chk("ill_flag", out_illegal, 1);
    chk("ill_we", out_reg_we, 0);
    chk("ill_class", out_class, 0);
    cyc();

    // saturation: four addi x3 with no writeback
    in_inst = 32'h0010_0193; in_valid = 1;
    cyc(); cyc(); cyc();
    neg(); chk("sat_stall", in_ready, 0);
    cyc(); wb_valid = 1; wb_rd = 3;
    neg(); chk("sat_stall_wb_cycle", in_ready, 0);
    cyc(); wb_valid = 0;
    neg(); chk("sat_released", in_ready, 1);
    cyc(); in_valid = 0;
    neg(); chk("sat_fourth_issued", out_valid, 1);
    cyc(); wb_valid = 1; wb_rd = 3;
    cyc(); cyc(); cyc(); wb_valid = 0;

    // backpressure holds outputs, then flush squashes
    out_ready = 0; in_pc = 64'h2000; in_inst = 32'h0070_0213; in_valid = 1;
    cyc(); in_pc = 64'h2004; in_inst = 32'h0090_0313;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("hold_valid", out_valid, 1);
      chk("hold_imm", out_imm, 64'd7);
      chk("hold_pc", out_pc, 64'h2000);
      chk("hold_in_ready", in_ready, 0);
      cyc();
    end
    flush = 1;
    neg(); chk("flush_in_ready", in_ready, 0);
    cyc(); flush = 0; in_valid = 0; out_ready = 1;
    neg(); chk("flush_cleared", out_valid, 0);
    // flush coinciding with out_ready: transfer must not be counted
    in_inst = 32'h0070_0213; in_valid = 1;
    cyc(); in_valid = 0; flush = 1;
    cyc(); flush = 0;
    in_inst = 32'h0002_03B3; in_valid = 1;
    neg(); chk("flush_not_counted", in_ready, 1);
    cyc(); in_valid = 0;
    cyc(); wb_valid = 1; wb_rd = 7;
    cyc(); wb_valid = 0;

    // addi x0,x0,1 never writes
    in_inst = 32'h0010_0013; in_valid = 1;
    cyc(); in_valid = 0;
    neg();
    chk("x0_valid", out_valid, 1);
    chk("x0_we", out_reg_we, 0);
    cyc();

    // reset while stalled
    out_ready = 0; in_inst = 32'h0080_0413; in_valid = 1;
    cyc(); in_inst = 32'h0004_04B3;
    neg(); chk("pre_reset_stall", in_ready, 0);
    cyc(); rst = 1;
    neg();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_pc", out_pc, 0);
    chk("midrst_in_ready", in_ready, 1);
    cyc(); rst = 0; in_valid = 0; out_ready = 1;
    cyc();

    // RV32 / RV-E instance
    s_in_pc = 32'h3000; s_in_inst = 32'h8000_02B7; s_in_valid = 1;
    cyc(); s_in_inst = 32'h0010_009B;
    neg();
    chk("rv32_lui_imm", {32'd0, s_out_imm}, 64'h8000_0000);
    chk("rv32_lui_legal", s_out_illegal, 0);
    cyc(); s_in_inst = 32'h0010_0893;
    neg();
    chk("rv32_addiw_illegal", s_out_illegal, 1);
    chk("rv32_addiw_we", s_out_reg_we, 0);
    cyc(); s_in_inst = 32'h0010_0793;
    neg(); chk("rve_rd17_illegal", s_out_illegal, 1);
    cyc(); s_in_valid = 0;
    neg();
    chk("rve_rd15_legal", s_out_illegal, 0);
    chk("rve_rd15_we", s_out_reg_we, 1);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
